frame_cmd_scheduler: RTL and testbench

//  Pops command packets from the UART packet FIFO, decodes the opcode and sequences the framebuffer.
//  Two kinds of packet: pixel-write packets, which write payload bytes into video memory, and

---
 rtl/frame_cmd_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_frame_cmd_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_cmd_scheduler.sv
// frame_cmd_scheduler
// Pops command packets from the show-ahead packet FIFO, decodes the opcode
// and either streams pixel bytes into the framebuffer write port or moves the
// VGA scan-out base. Base changes wait for a rising edge of vblank so the
// display never tears.
module frame_cmd_scheduler #(
    parameter int                SIZE      = 256,
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(49152),
    parameter int                HDR_BYTES = 7
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [8*SIZE-1:0]   fifo_data,
    output logic                fifo_rd_en,
    input  logic                vblank,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [7:0]          fb_wdata,
    input  logic                fb_ready,
    output logic [ADDR_W-1:0]   vga_base,
    output logic                busy,
    output logic                err_opcode,
    output logic                err_range
);

    localparam logic [7:0]    OP_SEL0   = 8'h01;
    localparam logic [7:0]    OP_SEL1   = 8'h02;
    localparam logic [7:0]    OP_TOGGLE = 8'h03;
    localparam logic [7:0]    OP_WRITE  = 8'h10;
    localparam logic [7:0]    MAX_COUNT = 8'(SIZE - HDR_BYTES);
    localparam int            SEL_W     = $clog2(SIZE) + 1;
    // One past the last framebuffer address; a write may end exactly here.
    localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WRITE,
        WAIT_VBL
    } state_t;

    state_t             state;
    logic [8*SIZE-1:0]  pkt;
    logic [7:0]         idx;
    logic               image;
    logic               target;
    logic               vblank_q;

    logic [7:0]         pkt_op;
    logic [7:0]         pkt_count;
    logic [ADDR_W-1:0]  pkt_addr;
    logic [ADDR_W:0]    pkt_end;
    logic               range_bad;
    logic               sel_target;
    logic [SEL_W-1:0]   next_sel;
    logic [7:0]         next_byte;
    logic [7:0]         first_byte;

    // Header field extraction, range check and payload byte selection.
    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        pkt_op     = pkt[16 +: 8];
        pkt_addr   = pkt[24 +: ADDR_W];
        pkt_count  = pkt[48 +: 8];
        pkt_end    = {1'b0, pkt_addr} + {{(ADDR_W-7){1'b0}}, pkt_count};
        range_bad  = (pkt_count > MAX_COUNT) || (pkt_end > ADDR_LIMIT);
        next_sel   = SEL_W'(HDR_BYTES) + SEL_W'(idx) + SEL_W'(1);
        next_byte  = pkt[{next_sel, 3'b000} +: 8];
        first_byte = pkt[8*HDR_BYTES +: 8];
        sel_target = ~image;
        case (pkt_op)
            OP_SEL0: sel_target = 1'b0;
            OP_SEL1: sel_target = 1'b1;
            default: sel_target = ~image;
        endcase
    end

    // Capture the head packet at the moment it is popped.
    // NOTE: the packet register is wide datapath storage that is always loaded before it is read, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && !fifo_empty) begin
            pkt <= fifo_data;
        end
    end

    // Command sequencer: pop, decode, stream pixels or wait for vblank.
    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            vga_base   <= '0;
            busy       <= 1'b0;
            err_opcode <= 1'b0;
            err_range  <= 1'b0;
            image      <= 1'b0;
            target     <= 1'b0;
            idx        <= '0;
            vblank_q   <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            fifo_rd_en <= 1'b0;
            err_opcode <= 1'b0;
            err_range  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    case (pkt_op)
                        OP_WRITE: begin
                            if (pkt_count == 8'd0) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else if (range_bad) begin
                                err_range <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                idx      <= '0;
                                fb_we    <= 1'b1;
                                fb_addr  <= pkt_addr;
                                fb_wdata <= first_byte;
                                state    <= WRITE;
                            end
                        end
                        OP_SEL0, OP_SEL1, OP_TOGGLE: begin
                            if (sel_target == image) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                target <= sel_target;
                                state  <= WAIT_VBL;
                            end
                        end
                        default: begin
                            err_opcode <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    endcase
                end
                WRITE: begin
                    // Address and data hold while the framebuffer stalls.
                    if (fb_ready) begin
                        if (idx == pkt_count - 8'd1) begin
                            fb_we <= 1'b0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx      <= idx + 8'd1;
                            fb_addr  <= fb_addr + ADDR_W'(1);
                            fb_wdata <= next_byte;
                        end
                    end
                end
                WAIT_VBL: begin
                    if (vblank && !vblank_q) begin
                        image    <= target;
                        vga_base <= target ? BASE_ADDR : '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Bench for frame_cmd_scheduler: a queue-backed show-ahead FIFO feeds packets,
// a packet-level model predicts pops, writes, errors and base swaps, and a
// monitor compares every DUT event against those predictions.
module tb_frame_cmd_scheduler;

    localparam int SIZE   = 256;
    localparam int ADDR_W = 17;
    localparam int HDR    = 7;
    localparam int BASE1  = 49152;

    logic                CLK = 1'b0;
    logic                rst = 1'b0;
    logic                fifo_empty = 1'b1;
    logic [8*SIZE-1:0]   fifo_data = '0;
    logic                fifo_rd_en;
    logic                vblank = 1'b0;
    logic                fb_we;
    logic [ADDR_W-1:0]   fb_addr;
    logic [7:0]          fb_wdata;
    logic                fb_ready = 1'b1;
    logic [ADDR_W-1:0]   vga_base;
    logic                busy;
    logic                err_opcode;
    logic                err_range;

    frame_cmd_scheduler dut (
        .CLK        (CLK),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .vblank     (vblank),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_ready   (fb_ready),
        .vga_base   (vga_base),
        .busy       (busy),
        .err_opcode (err_opcode),
        .err_range  (err_range)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Bench FIFO and scoreboard queues
    logic [8*SIZE-1:0] pq[$];
    logic [24:0]       exp_wr[$];   // {addr, data}
    int                exp_err[$];  // 1 = opcode, 2 = range
    int                exp_base[$];
    int                exp_pop[$];  // swaps that must be visible before this pop

    // Packet-level model state
    int m_image = 0;
    int m_swaps = 0;

    // Monitor statistics
    int pops_seen = 0, wr_seen = 0, swaps_seen = 0, n_err_o = 0, n_err_r = 0;
    logic [ADDR_W-1:0] last_base = '0;
    bit                stall_q = 0;
    logic [ADDR_W-1:0] stall_addr;
    logic [7:0]        stall_data;
    logic [24:0]       ew;
    int                ei;

    bit rnd_ready = 0;
    bit rnd_vbl   = 0;
    int vcnt      = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Show-ahead FIFO: pop on the edge where fifo_rd_en was high.
    always begin
        bit popped;
        @(posedge CLK);
        popped = fifo_rd_en;
        #1;
        if (popped && pq.size() != 0) void'(pq.pop_front());
        fifo_empty = (pq.size() == 0);
        fifo_data  = (pq.size() == 0) ? '0 : pq[0];
    end

    // Random backpressure and vertical blank generators
    always begin
        @(posedge CLK);
        #1;
        if (rnd_ready) fb_ready = ($urandom_range(0, 3) != 0);
        if (rnd_vbl) begin
            vcnt   = (vcnt + 1) % 37;
            vblank = (vcnt < 5);
        end
    end

    // Monitor: compare every DUT event against the predicted queues.
    always @(negedge CLK) begin
        if (!rst) begin
            stall_q = 0;
        end else begin
            if (stall_q) begin
                check("stall_we_held", 32'(fb_we), 32'd1);
                check("stall_addr_held", 32'(fb_addr), 32'(stall_addr));
                check("stall_data_held", 32'(fb_wdata), 32'(stall_data));
            end
            stall_q    = fb_we && !fb_ready;
            stall_addr = fb_addr;
            stall_data = fb_wdata;

            if (fifo_rd_en) begin
                pops_seen++;
                check("pop_expected", 32'(exp_pop.size() != 0), 32'd1);
                if (exp_pop.size() != 0) begin
                    ei = exp_pop.pop_front();
                    check("pop_after_swaps", 32'(swaps_seen), 32'(ei));
                end
            end
            if (fb_we && fb_ready) begin
                wr_seen++;
                check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(ew[24:8]));
                    check("wr_data", 32'(fb_wdata), 32'(ew[7:0]));
                end
            end
            if (err_range) begin
                n_err_r++;
                check("err_range_expected", 32'(exp_err.size() != 0), 32'd1);
                if (exp_err.size() != 0) begin
                    ei = exp_err.pop_front();
                    check("err_kind_range", 32'd2, 32'(ei));
                end
            end
            if (err_opcode) begin
                n_err_o++;
                check("err_opcode_expected", 32'(exp_err.size() != 0), 32'd1);
                if (exp_err.size() != 0) begin
                    ei = exp_err.pop_front();
                    check("err_kind_opcode", 32'd1, 32'(ei));
                end
            end
            if (vga_base !== last_base) begin
                swaps_seen++;
                check("swap_in_vblank", 32'(vblank), 32'd1);
                check("swap_expected", 32'(exp_base.size() != 0), 32'd1);
                if (exp_base.size() != 0) begin
                    ei = exp_base.pop_front();
                    check("swap_value", 32'(vga_base), 32'(ei));
                end
                last_base = vga_base;
            end
        end
    end

    // Build a packet, predict its effect and queue it in the FIFO.
    task automatic send(input int op, input int addr24, input int n, input int dbase, input bit rnd);
        logic [8*SIZE-1:0] p;
        logic [7:0]        d[256];
        int                a;
        int                tgt;
        for (int k = 0; k < SIZE; k++) p[8*k +: 8] = 8'($urandom);
        p[16 +: 8] = 8'(op);
        p[24 +: 24] = 24'(addr24);
        p[48 +: 8] = 8'(n);
        for (int i = 0; i < n && HDR + i < SIZE; i++) begin
            d[i] = rnd ? 8'($urandom) : 8'(dbase + i);
            p[8*(HDR+i) +: 8] = d[i];
        end
        exp_pop.push_back(m_swaps);
        a = addr24 & ((1 << ADDR_W) - 1);
        if (op == 'h10) begin
            if (n == 0) begin
                // empty write: nothing happens
            end else if (n > SIZE - HDR || a + n > (1 << ADDR_W)) begin
                exp_err.push_back(2);
            end else begin
                for (int i = 0; i < n; i++) exp_wr.push_back({17'(a + i), d[i]});
            end
        end else if (op == 1 || op == 2 || op == 3) begin
            tgt = (op == 1) ? 0 : (op == 2) ? 1 : 1 - m_image;
            if (tgt != m_image) begin
                m_image = tgt;
                m_swaps++;
                exp_base.push_back(tgt != 0 ? BASE1 : 0);
            end
        end else begin
            exp_err.push_back(1);
        end
        pq.push_back(p);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(pq.size() == 0 && fifo_empty && !busy && !fifo_rd_en) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("idle_within_budget", 32'(n >= budget), 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic pulse_vblank(input int cycles);
        @(posedge CLK); #1 vblank = 1'b1;
        repeat (cycles) @(posedge CLK);
        #1 vblank = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, w0, e0, lat, hold, op, addr, n, r;

        // Reset values
        #1;
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        check("rst_vga_base", 32'(vga_base), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_opcode", 32'(err_opcode), 32'd0);
        check("rst_err_range", 32'(err_range), 32'd0);
        repeat (3) @(negedge CLK);
        rst = 1'b1;

        // 1: empty FIFO; the monitor flags any stray pop, write or error
        repeat (100) @(negedge CLK);
        check("idle_vga_base", 32'(vga_base), 32'd0);
        check("idle_pops", 32'(pops_seen), 32'd0);

        // 2: simple 4-byte write with fb_ready held high
        p0 = pops_seen; w0 = wr_seen;
        send('h10, 'h00100, 4, 'hA0, 0);
        lat = 0;
        for (int i = 0; i < 40 && !fifo_rd_en; i++) @(negedge CLK);
        check("t2_pop_seen", 32'(fifo_rd_en), 32'd1);
        while (!fb_we && lat < 5) begin @(negedge CLK); lat++; end
        check("t2_first_we_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
        wait_idle(100);
        check("t2_beats", 32'(wr_seen - w0), 32'd4);
        check("t2_pops", 32'(pops_seen - p0), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);

        // 3: stall on the second beat for 3 cycles
        w0 = wr_seen;
        send('h10, 'h00100, 4, 'hA0, 0);
        for (int i = 0; i < 40 && !fb_we; i++) @(negedge CLK);
        check("t3_we_seen", 32'(fb_we), 32'd1);
        @(posedge CLK); #1 fb_ready = 1'b0;
        hold = 0;
        repeat (3) begin
            @(negedge CLK);
            if (fb_we && fb_addr == 17'h00101 && fb_wdata == 8'hA1) hold++;
        end
        @(posedge CLK); #1 fb_ready = 1'b1;
        @(negedge CLK);
        if (fb_we && fb_addr == 17'h00101 && fb_wdata == 8'hA1) hold++;
        check("t3_beat2_hold_cycles", 32'(hold), 32'd4);
        wait_idle(100);
        check("t3_beats", 32'(wr_seen - w0), 32'd4);

        // 4: deferred image swap blocks the packet behind it
        p0 = pops_seen;
        send('h02, 0, 0, 0, 1);
        send('h10, 'h00300, 3, 'hB0, 0);
        repeat (20) @(negedge CLK);
        check("t4_base_before_vblank", 32'(vga_base), 32'd0);
        check("t4_pops_before_vblank", 32'(pops_seen - p0), 32'd1);
        check("t4_busy_waiting", 32'(busy), 32'd1);
        pulse_vblank(4);
        wait_idle(200);
        check("t4_base_after_vblank", 32'(vga_base), 32'(BASE1));
        check("t4_pops_after", 32'(pops_seen - p0), 32'd2);
        send('h02, 0, 0, 0, 1);
        wait_idle(30);
        check("t4_repeat_select_base", 32'(vga_base), 32'(BASE1));
        check("t4_repeat_select_pops", 32'(pops_seen - p0), 32'd3);

        // 5: range / opcode errors and range boundaries
        p0 = pops_seen; e0 = n_err_r; w0 = n_err_o;
        send('h10, 'h1FFFE, 4, 'hC0, 0);
        send('h7F, 0, 0, 0, 1);
        send('h10, 'h1FFFC, 4, 'hD0, 0);
        send('h10, 'h00000, 250, 0, 1);
        send('h10, 'h00000, 249, 0, 1);
        send('h10, 'hFE0400, 3, 'hE0, 0);
        send('h10, 'h00020, 0, 0, 1);
        wait_idle(2000);
        check("t5_err_range_count", 32'(n_err_r - e0), 32'd2);
        check("t5_err_opcode_count", 32'(n_err_o - w0), 32'd1);
        check("t5_pops", 32'(pops_seen - p0), 32'd7);

        // Randomized packets with random backpressure and frame timing
        rnd_ready = 1; rnd_vbl = 1;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            addr = $urandom_range(0, 'hFFFFFF);
            n = $urandom_range(0, 12);
            if (r <= 4) op = 'h10;
            else if (r == 5) op = 'h01;
            else if (r == 6) op = 'h02;
            else if (r == 7) op = 'h03;
            else if (r == 8) begin
                op = $urandom_range(0, 255);
                while (op == 1 || op == 2 || op == 3 || op == 'h10) op = $urandom_range(0, 255);
            end else begin
                op = 'h10;
                addr = (1 << ADDR_W) - $urandom_range(1, 16);
                n = ($urandom_range(0, 3) == 0) ? 250 : $urandom_range(1, 16);
            end
            send(op, addr, n, 0, 1);
            repeat ($urandom_range(0, 5)) @(posedge CLK);
        end
        wait_idle(20000);
        rnd_ready = 0; rnd_vbl = 0;
        @(posedge CLK); #1 fb_ready = 1'b1; vblank = 1'b0;
        repeat (2) @(negedge CLK);

        // 6: reset in the middle of an 8-byte write
        if (m_image == 0) begin
            send('h02, 0, 0, 0, 1);
            repeat (4) @(negedge CLK);
            pulse_vblank(3);
            wait_idle(100);
        end
        check("t6_base_before_reset", 32'(vga_base), 32'(BASE1));
        w0 = wr_seen;
        send('h10, 'h00200, 8, 'h50, 0);
        for (int i = 0; i < 40 && !(fb_we && fb_addr == 17'h00201); i++) @(negedge CLK);
        check("t6_beat2_presented", 32'(fb_we && fb_addr == 17'h00201), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_fb_we_on_reset", 32'(fb_we), 32'd0);
        check("t6_busy_on_reset", 32'(busy), 32'd0);
        check("t6_vga_base_on_reset", 32'(vga_base), 32'd0);
        check("t6_fifo_rd_en_on_reset", 32'(fifo_rd_en), 32'd0);
        exp_wr.delete(); exp_err.delete(); exp_base.delete(); exp_pop.delete();
        m_image = 0; m_swaps = 0; swaps_seen = 0; last_base = '0;
        @(negedge CLK);
        rst = 1'b1;
        w0 = wr_seen;
        repeat (10) @(negedge CLK);
        check("t6_no_writes_after_reset", 32'(wr_seen - w0), 32'd0);
        send('h10, 'h00500, 3, 'h70, 0);
        wait_idle(100);
        check("t6_writes_resume", 32'(wr_seen - w0), 32'd3);

        // Every prediction must have been consumed
        check("left_writes", 32'(exp_wr.size()), 32'd0);
        check("left_errors", 32'(exp_err.size()), 32'd0);
        check("left_swaps", 32'(exp_base.size()), 32'd0);
        check("left_pops", 32'(exp_pop.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
